// File: rtl/bitscan_iter_if.sv
// Handshake bundle for the set-bit iterator: word-in channel and index-beat-out channel.
// The slave modport is the iterator's view; master is the producer/consumer side.
interface bitscan_iter_if #(
  parameter int ORDER = 3
);
  localparam int W = 2 ** ORDER;

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [ORDER-1:0] out_index;
  logic [ORDER:0]   out_count;
  logic             out_last;
  logic             out_empty;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_index, out_count, out_last, out_empty
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_index, out_count, out_last, out_empty
  );
endinterface

// File: rtl/bitscan_iter.sv
// Streaming set-bit iterator: loads a word, then emits one index beat per matching bit,
// LSB-first or MSB-first, optionally scanning zeros; an all-clear word yields one empty beat.
module bitscan_iter #(
  parameter int ORDER = 3
) (
  input  logic          clock,
  input  logic          reset,
  bitscan_iter_if.slave bus
);
  localparam int W = 2 ** ORDER;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t           state;
  logic [W-1:0]     resid;
  logic [ORDER:0]   cnt;
  logic             dir_msb;

  logic [ORDER-1:0] idx;
  logic [W-1:0]     bit_mask;
  logic             scanning;
  logic             is_empty;
  logic             one_hot;
  logic             last;
  logic             beat_take;
  logic             load;

  function automatic logic [ORDER-1:0] lsb_idx(input logic [W-1:0] v);
    lsb_idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (v[i]) lsb_idx = ORDER'(i);
    end
  endfunction

  function automatic logic [ORDER-1:0] msb_idx(input logic [W-1:0] v);
    msb_idx = '0;
    for (int i = 0; i < W; i++) begin
      if (v[i]) msb_idx = ORDER'(i);
    end
  endfunction

  // Combinational priority search on the residual word
  always_comb begin
    idx       = dir_msb ? msb_idx(resid) : lsb_idx(resid);
    bit_mask  = W'(1) << idx;
    scanning  = (state == SCAN);
    is_empty  = (resid == '0);
    one_hot   = !is_empty && ((resid & (resid - W'(1))) == '0);
    last      = scanning && (is_empty || one_hot);
    beat_take = scanning && bus.out_ready;
  end

  // A new word may enter while the final beat of the previous one is consumed
  assign bus.in_ready  = (state == IDLE) || (beat_take && last);
  assign load          = bus.in_valid && bus.in_ready;

  assign bus.out_valid = scanning;
  assign bus.out_index = scanning ? idx : '0;
  assign bus.out_count = scanning ? cnt : '0;
  assign bus.out_last  = last;
  assign bus.out_empty = scanning && is_empty;

  // Iterator state: residual bits still to report, beat ordinal, scan direction
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      resid   <= '0;
      cnt     <= '0;
      dir_msb <= 1'b0;
    end else if (load) begin
      state   <= SCAN;
      resid   <= bus.in_mode[1] ? ~bus.in_data : bus.in_data;
      dir_msb <= bus.in_mode[0];
      cnt     <= '0;
    end else if (beat_take) begin
      resid <= resid & ~bit_mask;
      cnt   <= cnt + (ORDER + 1)'(1);
      if (last) state <= IDLE;
    end
  end
endmodule
